// File: rtl/cfg_chain_loader.sv
// Configuration-chain controller: serialises a word stream onto the fabric's
// daisy-chained programming path and verifies it by recirculating readback.
module cfg_chain_loader #(
    parameter int unsigned ROWS         = 8,
    parameter int unsigned BITS_PER_ROW = 1024,
    parameter int unsigned WORD_W       = 32,
    parameter int unsigned CNT_W        = $clog2(ROWS*BITS_PER_ROW+1)
) (
    input  logic              prog_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              chain_in,
    output logic              chain_en,
    input  logic              chain_out,
    output logic              busy,
    output logic              done,
    output logic [15:0]       crc,
    output logic              crc_err,
    output logic [CNT_W-1:0]  bit_cnt
);

    localparam int unsigned TOTAL  = ROWS * BITS_PER_ROW;
    localparam int unsigned NWORDS = TOTAL / WORD_W;
    localparam int unsigned SH_W   = $clog2(WORD_W + 1);
    localparam int unsigned WC_W   = $clog2(NWORDS + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RDBK} state_t;

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] hold;
    logic [SH_W-1:0]   sh_cnt;
    logic              hold_vld;
    logic [WC_W-1:0]   words_acc;
    logic [15:0]       crc_ref;

    logic        shifting;
    logic        sh_drain;
    logic        accept;
    logic        last_bit;
    logic        crc_fb;
    logic [15:0] crc_nxt;

    // Chain-side decode: in readback the chain's output is looped straight back.
    assign shifting = (state == LOAD) && (sh_cnt != '0);
    assign sh_drain = !shifting || (sh_cnt == SH_W'(1));
    assign chain_en = (state == RDBK) || shifting;
    assign chain_in = (state == RDBK) ? chain_out : (shifting & shreg[0]);
    assign s_ready  = (state == LOAD) && !hold_vld && (words_acc < WC_W'(NWORDS));
    assign accept   = s_valid && s_ready;
    assign last_bit = chain_en && (bit_cnt == CNT_W'(TOTAL - 1));

    // Bit-serial CRC-16-CCITT over whatever bit enters the chain this cycle
    assign crc_fb  = crc[15] ^ chain_in;
    assign crc_nxt = {crc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);

    always_ff @(posedge prog_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            crc       <= 16'hFFFF;
            crc_ref   <= 16'hFFFF;
            crc_err   <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            hold      <= '0;
            sh_cnt    <= '0;
            hold_vld  <= 1'b0;
            words_acc <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= mode ? RDBK : LOAD;
                        busy      <= 1'b1;
                        crc       <= 16'hFFFF;
                        bit_cnt   <= '0;
                        sh_cnt    <= '0;
                        hold_vld  <= 1'b0;
                        words_acc <= '0;
                    end
                end
                LOAD, RDBK: begin
                    if (chain_en) begin
                        crc <= crc_nxt;
                        if (bit_cnt != CNT_W'(TOTAL))
                            bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                    // Word feed: a draining shift register takes the buffer, else a fresh word
                    if (state == LOAD) begin
                        if (shifting) begin
                            shreg  <= shreg >> 1;
                            sh_cnt <= sh_cnt - SH_W'(1);
                        end
                        if (sh_drain) begin
                            if (hold_vld) begin
                                shreg    <= hold;
                                sh_cnt   <= SH_W'(WORD_W);
                                hold_vld <= 1'b0;
                            end else if (accept) begin
                                shreg  <= s_data;
                                sh_cnt <= SH_W'(WORD_W);
                            end
                        end else if (accept) begin
                            hold     <= s_data;
                            hold_vld <= 1'b1;
                        end
                        if (accept)
                            words_acc <= words_acc + WC_W'(1);
                    end
                    if (abort) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        sh_cnt   <= '0;
                        hold_vld <= 1'b0;
                    end else if (last_bit) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sh_cnt   <= '0;
                        hold_vld <= 1'b0;
                        if (state == LOAD)
                            crc_ref <= crc_nxt;
                        else
                            crc_err <= (crc_nxt != crc_ref);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
